// File: rtl/visitor_gate_pkg.sv
// Shared constants, types and helpers for the visitor gate driver.
package visitor_gate_pkg;

  // Count ceiling shared by the driver and the word counter.
  localparam int unsigned MAX_COUNT = 20;

  // Parked word: contains neither "00" nor "11", so it never moves the counter.
  localparam logic [4:0] IDLE_WORD = 5'b01010;

  // Entry 0 is the rightmost element of each concatenation.
  localparam logic [3:0][4:0] HIPS_TABLE = {5'b01001, 5'b10001, 5'b00101, 5'b10010};
  localparam logic [3:0][4:0] NERD_TABLE = {5'b10110, 5'b11010, 5'b01101, 5'b11111};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CHECK
  } state_e;

  // Hipsterian: at least one adjacent "00" pair.
  function automatic logic is_hips(input logic [4:0] w);
    return |(~(w[4:1] | w[3:0]));
  endfunction

  // Nerdian: at least one adjacent "11" pair.
  function automatic logic is_nerd(input logic [4:0] w);
    return |(w[4:1] & w[3:0]);
  endfunction

  function automatic logic [4:0] table_word(input logic sel, input logic [1:0] idx);
    return sel ? NERD_TABLE[idx] : HIPS_TABLE[idx];
  endfunction

  // Two BCD digits versus a binary count; out-of-range digits always mismatch.
  function automatic logic bcd_mismatch(input logic [7:0] d1, input logic [7:0] d0,
                                        input logic [4:0] expected);
    logic [7:0] value;
    value = 8'(d1 * 8'd10) + d0;
    return (d1 > 8'd9) || (d0 > 8'd9) || (value != {3'b000, expected});
  endfunction

endpackage

// File: rtl/visitor_gate_driver_if.sv
// Command handshake plus the word-counter stream and its read-back lines.
// master: the control logic / word counter side; slave: the driver.
interface visitor_gate_driver_if #(
  parameter int unsigned CMD_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_sel;
  logic             cmd_dir;
  logic [CMD_W-1:0] cmd_count;
  logic [4:0]       word;
  logic             selection;
  logic             mode;
  logic [7:0]       fb_h1;
  logic [7:0]       fb_h0;
  logic [7:0]       fb_n1;
  logic [7:0]       fb_n0;
  logic             fb_warning;

  modport master (
    output cmd_valid, cmd_sel, cmd_dir, cmd_count,
    output fb_h1, fb_h0, fb_n1, fb_n0, fb_warning,
    input  cmd_ready, word, selection, mode
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_dir, cmd_count,
    input  fb_h1, fb_h0, fb_n1, fb_n0, fb_warning,
    output cmd_ready, word, selection, mode
  );
endinterface

// File: rtl/visitor_shadow_counter.sv
// Mirror of one word-counter count: wraps to 0 past MAX_COUNT, saturates at 0.
module visitor_shadow_counter
  import visitor_gate_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  output logic [4:0] count
);

  logic [4:0] count_q;

  // Apply one accepted word to the shadow count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 5'd0;
    end else if (en) begin
      if (up) begin
        count_q <= (count_q == 5'(MAX_COUNT)) ? 5'd0 : count_q + 5'd1;
      end else begin
        count_q <= (count_q == 5'd0) ? 5'd0 : count_q - 5'd1;
      end
    end
  end

  assign count = count_q;

endmodule

// File: rtl/visitor_gate_driver.sv
// Turns visit commands into the (word, selection, mode) stream for one word
// counter, shadows both counts and flags any divergence on read-back.
module visitor_gate_driver
  import visitor_gate_pkg::*;
#(
  parameter int unsigned CMD_W = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  visitor_gate_driver_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [4:0]            shadow_h,
  output logic [4:0]            shadow_n
);

  state_e     state_q;
  logic [4:0] word_q;
  logic       selection_q;
  logic       mode_q;
  logic [1:0] idx_q;
  logic [4:0] remaining_q;
  logic       done_q;
  logic       err_q;
  // Low on the first ISSUE edge: fb_warning then still reflects the idle word.
  logic       armed_q;

  logic [CMD_W-1:0] count_in;
  logic [4:0]       clamped;
  logic             word_ok;
  logic             en_h;
  logic             en_n;
  logic             fb_bad;

  // Clamp the requested count to the ceiling.
  always_comb begin
    count_in = bus.cmd_count;
    clamped  = (32'(count_in) > MAX_COUNT) ? 5'(MAX_COUNT) : 5'(count_in);
  end

  // Decide whether the word the counter samples at this edge moves a count.
  always_comb begin
    word_ok = selection_q ? is_nerd(word_q) : is_hips(word_q);
    en_h    = (state_q == ISSUE) && !selection_q && word_ok;
    en_n    = (state_q == ISSUE) && selection_q && word_ok;
    fb_bad  = bus.fb_warning
              || bcd_mismatch(bus.fb_h1, bus.fb_h0, shadow_h)
              || bcd_mismatch(bus.fb_n1, bus.fb_n0, shadow_n);
  end

  visitor_shadow_counter u_shadow_h (
    .clk   (CLK),
    .rst   (RST),
    .en    (en_h),
    .up    (mode_q),
    .count (shadow_h)
  );

  visitor_shadow_counter u_shadow_n (
    .clk   (CLK),
    .rst   (RST),
    .en    (en_n),
    .up    (mode_q),
    .count (shadow_n)
  );

  // Command FSM with registered counter-side outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      word_q      <= IDLE_WORD;
      selection_q <= 1'b0;
      mode_q      <= 1'b0;
      idx_q       <= 2'd0;
      remaining_q <= 5'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            err_q <= 1'b0;
            if (clamped == 5'd0) begin
              done_q <= 1'b1;
            end else begin
              word_q      <= table_word(bus.cmd_sel, idx_q);
              selection_q <= bus.cmd_sel;
              mode_q      <= bus.cmd_dir;
              idx_q       <= idx_q + 2'd1;
              remaining_q <= clamped;
              armed_q     <= 1'b0;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (armed_q && bus.fb_warning) begin
            err_q <= 1'b1;
          end
          armed_q <= 1'b1;
          if (remaining_q == 5'd1) begin
            word_q      <= IDLE_WORD;
            selection_q <= 1'b0;
            mode_q      <= 1'b0;
            state_q     <= CHECK;
          end else begin
            word_q      <= table_word(selection_q, idx_q);
            idx_q       <= idx_q + 2'd1;
            remaining_q <= remaining_q - 5'd1;
          end
        end
        CHECK: begin
          if (fb_bad) begin
            err_q <= 1'b1;
          end
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.word      = word_q;
  assign bus.selection = selection_q;
  assign bus.mode      = mode_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_visitor_gate_driver.sv
// Scoreboard bench: a behavioural word counter closes the loop, each command
// pushes its hand-computed completion record, a monitor pops it on done.
module tb_visitor_gate_driver;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       busy, done, err;
  logic [4:0] shadow_h, shadow_n;

  visitor_gate_driver_if #(.CMD_W(5)) bus ();

  visitor_gate_driver #(.CMD_W(5)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .shadow_h (shadow_h),
    .shadow_n (shadow_n)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic busy_seen = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural word counter (no reset, like the real one).
  int   h_cnt = 0;
  int   n_cnt = 0;
  logic warn_m = 1'b0;
  logic force_n0 = 1'b0;

  function automatic logic has_pair(input logic [4:0] w, input logic b);
    for (int i = 0; i < 4; i++) if (w[i] == b && w[i+1] == b) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge CLK) begin
    logic ok;
    ok = bus.selection ? has_pair(bus.word, 1'b1) : has_pair(bus.word, 1'b0);
    warn_m <= !ok;
    if (ok) begin
      if (bus.selection) begin
        if (bus.mode) n_cnt <= (n_cnt == 20) ? 0 : n_cnt + 1;
        else          n_cnt <= (n_cnt == 0) ? 0 : n_cnt - 1;
      end else begin
        if (bus.mode) h_cnt <= (h_cnt == 20) ? 0 : h_cnt + 1;
        else          h_cnt <= (h_cnt == 0) ? 0 : h_cnt - 1;
      end
    end
  end

  assign bus.fb_h1      = 8'(h_cnt / 10);
  assign bus.fb_h0      = 8'(h_cnt % 10);
  assign bus.fb_n1      = 8'(n_cnt / 10);
  assign bus.fb_n0      = force_n0 ? 8'd7 : 8'(n_cnt % 10);
  assign bus.fb_warning = warn_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic       err;
    logic [4:0] sh;
    logic [4:0] sn;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: every done pulse consumes one expected completion.
  always @(negedge CLK) begin
    if (busy) busy_seen = 1'b1;
    if (!RST && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_err"}, 32'(err), 32'(mon_e.err));
        chk({mon_e.name, "_shadow_h"}, 32'(shadow_h), 32'(mon_e.sh));
        chk({mon_e.name, "_shadow_n"}, 32'(shadow_n), 32'(mon_e.sn));
        chk({mon_e.name, "_done_cycle"}, 32'(cyc), 32'(mon_e.done_cyc));
      end
    end
  end

  // Offer one command, record its expected completion, wait for it.
  task automatic issue(input string name, input logic sel, input logic dir,
                       input logic [4:0] cnt, input logic e_err, input logic [4:0] e_sh,
                       input logic [4:0] e_sn, input int lat);
    exp_t e;
    int   w;
    w = 0;
    @(negedge CLK);
    while (!bus.cmd_ready && w < 50) begin
      @(negedge CLK);
      w++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready: got cmd_ready=0 after 50 cycles, expected 1", name);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_dir   = dir;
    bus.cmd_count = cnt;
    e.name     = name;
    e.err      = e_err;
    e.sh       = e_sh;
    e.sn       = e_sn;
    e.done_cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge CLK);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done within 100 cycles, expected done", name);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = 5'd0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_word", 32'(bus.word), 32'b01010);
    chk("rst_sel", 32'(bus.selection), 32'd0);
    chk("rst_mode", 32'(bus.mode), 32'd0);
    chk("rst_sh", 32'(shadow_h), 32'd0);
    chk("rst_sn", 32'(shadow_n), 32'd0);

    // 1: one hipsterian in; check the single word on the wire.
    fork
      issue("t1_h_in1", 1'b0, 1'b1, 5'd1, 1'b0, 5'd1, 5'd0, 2);
      begin
        @(negedge CLK);
        @(negedge CLK);
        chk("t1_word", 32'(bus.word), 32'b10010);
        chk("t1_mode", 32'(bus.mode), 32'd1);
        chk("t1_sel", 32'(bus.selection), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge CLK);
        chk("t1_word_idle", 32'(bus.word), 32'b01010);
        chk("t1_mode_idle", 32'(bus.mode), 32'd0);
      end
    join
    issue("t1_h_out1", 1'b0, 1'b0, 5'd1, 1'b0, 5'd0, 5'd0, 2);

    // 2: nerdians in then out past zero.
    issue("t2_n_in3", 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 5'd3, 4);
    issue("t2_n_out5", 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 5'd0, 6);

    // 3: fill to the ceiling, then wrap.
    issue("t3_h_in20", 1'b0, 1'b1, 5'd20, 1'b0, 5'd20, 5'd0, 21);
    chk("t3_fb_h1", 32'(bus.fb_h1), 32'd2);
    chk("t3_fb_h0", 32'(bus.fb_h0), 32'd0);
    issue("t3_h_wrap", 1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd0, 2);

    // 4: corrupted read-back, then recovery clears err.
    force_n0 = 1'b1;
    issue("t4_bad_fb", 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 5'd1, 2);
    force_n0 = 1'b0;
    issue("t4_clear", 1'b1, 1'b0, 5'd1, 1'b0, 5'd0, 5'd0, 2);

    // 5: zero count completes at once; oversize count clamps.
    busy_seen = 1'b0;
    issue("t5_zero", 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 0);
    chk("t5_no_busy", 32'(busy_seen), 32'd0);
    chk("t5_word_idle", 32'(bus.word), 32'b01010);
    issue("t5_clamp", 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 5'd20, 21);

    // 6: reset mid-ISSUE after four hipsterian words reached the counter.
    @(negedge CLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = 1'b0;
    bus.cmd_dir   = 1'b1;
    bus.cmd_count = 5'd10;
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk("t6_busy_before", 32'(busy), 32'd1);
    RST = 1'b1;
    #1;
    chk("t6_word", 32'(bus.word), 32'b01010);
    chk("t6_mode", 32'(bus.mode), 32'd0);
    chk("t6_sh", 32'(shadow_h), 32'd0);
    chk("t6_sn", 32'(shadow_n), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    issue("t6_desync", 1'b0, 1'b1, 5'd1, 1'b1, 5'd1, 5'd0, 2);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
